// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Includes state encoding, grant-owner values and the watchdog counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam int TMO_W = 16;

  function automatic arb_state_e owner_state(input logic owner);
    return (owner == OWN_DATA) ? ARB_DATA : ARB_FETCH;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Bus-response watchdog: counts stalled cycles of an outstanding transaction
// and flags expiry once the count reaches TIMEOUT_CYCLES.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;
  logic             at_limit;

  assign at_limit  = (cnt_q == LIMIT);
  assign expired_o = active_i && at_limit;

  // Saturates at the limit so a stale count in IDLE never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (active_i && !mem_ready_i && !at_limit) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for a single valid/ready memory port.
// Optional bus timeout watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              bus_fault
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_e        state_q;
  logic              last_grant_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;

  logic grant_en;
  logic grant_own;
  logic done;
  logic abort;

  // Handshake: a transaction is presented with mem_valid held stable until the
  // single-cycle mem_ready pulse; the owner's ready mirrors that pulse only
  // while the owner still asserts valid, otherwise the response is dropped.
  assign busy    = (state_q != ARB_IDLE);
  assign done    = busy && mem_ready;
  assign i_ready = (state_q == ARB_FETCH) && mem_ready && i_valid;
  assign d_ready = (state_q == ARB_DATA) && mem_ready && d_valid;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

  // Back-to-back hand-off only goes to the other side; a repeat request from
  // the same side takes a bubble through IDLE so the other side gets a look.
  always_comb begin
    grant_en  = 1'b0;
    grant_own = OWN_FETCH;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_valid && d_valid) begin
          grant_en  = 1'b1;
          grant_own = ~last_grant_q;
        end else if (i_valid) begin
          grant_en  = 1'b1;
          grant_own = OWN_FETCH;
        end else if (d_valid) begin
          grant_en  = 1'b1;
          grant_own = OWN_DATA;
        end
      end
      ARB_FETCH: begin
        if (mem_ready && d_valid) begin
          grant_en  = 1'b1;
          grant_own = OWN_DATA;
        end
      end
      ARB_DATA: begin
        if (mem_ready && i_valid) begin
          grant_en  = 1'b1;
          grant_own = OWN_FETCH;
        end
      end
      default: begin
        grant_en  = 1'b0;
        grant_own = OWN_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= OWN_DATA;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else if (grant_en) begin
      state_q      <= owner_state(grant_own);
      last_grant_q <= grant_own;
      mem_valid_q  <= 1'b1;
      if (grant_own == OWN_DATA) begin
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
        mem_wstrb_q <= d_wstrb;
      end else begin
        mem_addr_q  <= i_addr;
        mem_wdata_q <= '0;
        mem_wstrb_q <= '0;
      end
    end else if (done || abort) begin
      state_q     <= ARB_IDLE;
      mem_valid_q <= 1'b0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic wd_expired;
  logic bus_fault_q;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .rstn       (rstn),
    .clear_i    (grant_en),
    .active_i   (busy),
    .mem_ready_i(mem_ready),
    .expired_o  (wd_expired)
  );

  // A response landing on the expiry cycle wins over the abort.
  assign abort = wd_expired && !mem_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_fault_q <= 1'b0;
    end else begin
      bus_fault_q <= abort;
    end
  end

  assign bus_fault = bus_fault_q;
`else
  assign abort     = 1'b0;
  assign bus_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
// The timeout section is active when ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [31:0]       i_rdata;
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic              d_ready;
  logic [31:0]       d_rdata;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              bus_fault;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int i_done = 0;
  int d_done = 0;

  // {side (1 = data), rdata}
  logic [32:0] exp_q[$];

  mem_arbiter #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_valid  (i_valid),
    .i_addr   (i_addr),
    .i_ready  (i_ready),
    .i_rdata  (i_rdata),
    .d_valid  (d_valid),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_valid(mem_valid),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .bus_fault(bus_fault)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic respond(input logic [31:0] data, input bit expect_ready, input logic side);
    mem_ready = 1'b1;
    mem_rdata = data;
    if (expect_ready) exp_q.push_back({side, data});
  endtask

  // Scoreboard: every ready pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rstn === 1'b1 && (i_ready === 1'b1 || d_ready === 1'b1)) begin
      logic [32:0] e;
      chk("single_ready", {i_ready, d_ready} == 2'b11, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", {i_ready, d_ready}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("resp_side", d_ready, e[32]);
        chk("resp_data", d_ready ? d_rdata : i_rdata, e[31:0]);
        if (d_ready) d_done++;
        else i_done++;
      end
    end
  end

  initial begin
    int i0, d0;
    bit seen;
    int k;

    rstn = 1'b0; i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;

    // Reset state
    smp();
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_fault", bus_fault, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    tick();
    rstn = 1'b1;
    tick();

    // Single fetch
    i0 = i_done; d0 = d_done;
    i_valid = 1'b1; i_addr = 32'h100;
    smp();
    chk("f1_no_valid_yet", mem_valid, 1'b0);
    tick();
    smp();
    chk("f1_mem_valid", mem_valid, 1'b1);
    chk("f1_mem_addr", mem_addr, 32'h100);
    chk("f1_mem_wstrb", mem_wstrb, 4'h0);
    chk("f1_mem_wdata", mem_wdata, 32'h0);
    chk("f1_busy", busy, 1'b1);
    tick();
    smp();
    chk("f1_hold_addr", mem_addr, 32'h100);
    tick();
    respond(32'hDEADBEEF, 1'b1, 1'b0);
    smp();
    chk("f1_i_ready", i_ready, 1'b1);
    chk("f1_d_ready", d_ready, 1'b0);
    tick();
    mem_ready = 1'b0; i_valid = 1'b0;
    smp();
    chk("f1_idle_busy", busy, 1'b0);
    chk("f1_idle_valid", mem_valid, 1'b0);
    chk("f1_i_count", i_done - i0, 1);
    chk("f1_d_count", d_done - d0, 0);

    // Contention right after reset: fetch first, zero-bubble hand-off to data
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    i_valid = 1'b1; i_addr = 32'h180;
    d_valid = 1'b1; d_addr = 32'h200; d_wstrb = 4'b0011; d_wdata = 32'h1234;
    tick();
    smp();
    chk("c_first_addr", mem_addr, 32'h180);
    chk("c_first_wstrb", mem_wstrb, 4'h0);
    tick();
    respond(32'h11111111, 1'b1, 1'b0);
    tick();
    mem_ready = 1'b0; i_valid = 1'b0;
    smp();
    chk("c_data_valid", mem_valid, 1'b1);
    chk("c_data_addr", mem_addr, 32'h200);
    chk("c_data_wstrb", mem_wstrb, 4'b0011);
    chk("c_data_wdata", mem_wdata, 32'h1234);
    tick();
    respond(32'h22222222, 1'b1, 1'b1);
    tick();
    mem_ready = 1'b0; d_valid = 1'b0;
    smp();
    chk("c_idle_busy", busy, 1'b0);

    // Starvation: both held valid for 10 transactions
    i0 = i_done; d0 = d_done;
    i_valid = 1'b1; i_addr = 32'h1000;
    d_valid = 1'b1; d_addr = 32'h2000; d_wstrb = 4'hF; d_wdata = 32'hCAFE0000;
    tick();
    for (int t = 0; t < 10; t++) begin
      smp();
      chk("s_valid", mem_valid, 1'b1);
      chk("s_addr", mem_addr, (t % 2 == 0) ? 32'h1000 : 32'h2000);
      chk("s_wstrb", mem_wstrb, (t % 2 == 0) ? 4'h0 : 4'hF);
      tick();
      respond(32'h5000 + 32'(t), 1'b1, (t % 2 == 1));
      tick();
      mem_ready = 1'b0;
    end
    i_valid = 1'b0; d_valid = 1'b0;
    smp();
    chk("s_eleventh_addr", mem_addr, 32'h1000);
    tick();
    respond(32'h0BAD0BAD, 1'b0, 1'b0);
    smp();
    chk("s_dropped_ready", i_ready, 1'b0);
    tick();
    mem_ready = 1'b0;
    smp();
    chk("s_idle_busy", busy, 1'b0);
    chk("s_i_count", i_done - i0, 5);
    chk("s_d_count", d_done - d0, 5);

    // Requester drop after grant
    tick();
    i_valid = 1'b1; i_addr = 32'h300;
    tick();
    i_valid = 1'b0;
    smp();
    chk("drop_valid", mem_valid, 1'b1);
    chk("drop_addr", mem_addr, 32'h300);
    tick();
    smp();
    chk("drop_hold_addr", mem_addr, 32'h300);
    tick();
    tick();
    respond(32'h33333333, 1'b0, 1'b0);
    smp();
    chk("drop_i_ready", i_ready, 1'b0);
    chk("drop_d_ready", d_ready, 1'b0);
    chk("drop_addr_at_ready", mem_addr, 32'h300);
    tick();
    mem_ready = 1'b0;
    smp();
    chk("drop_idle", busy, 1'b0);

    // Asynchronous reset in the middle of a data transaction
    tick();
    d_valid = 1'b1; d_addr = 32'h400; d_wstrb = 4'h0;
    tick();
    smp();
    chk("ar_busy_before", busy, 1'b1);
    chk("ar_addr_before", mem_addr, 32'h400);
    #2;
    rstn = 1'b0; d_valid = 1'b0;
    #1;
    chk("ar_mem_valid", mem_valid, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_mem_addr", mem_addr, 32'h0);
    tick();
    rstn = 1'b1;
    tick();
    respond(32'h44444444, 1'b0, 1'b1);
    smp();
    chk("ar_late_d_ready", d_ready, 1'b0);
    chk("ar_late_busy", busy, 1'b0);
    tick();
    mem_ready = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // Timeout abort with TIMEOUT_CYCLES = 4, then a normal regrant
    i_valid = 1'b1; i_addr = 32'h500;
    seen = 1'b0; k = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      tick();
      if (n == 1) i_addr = 32'h600;
      smp();
      if (bus_fault === 1'b1) begin
        seen = 1'b1;
        k = n;
      end
    end
    chk("tmo_seen", seen, 1'b1);
    chk("tmo_edge", k, 6);
    chk("tmo_mem_valid", mem_valid, 1'b0);
    chk("tmo_i_ready", i_ready, 1'b0);
    tick();
    smp();
    chk("tmo_fault_pulse", bus_fault, 1'b0);
    chk("tmo_regrant_valid", mem_valid, 1'b1);
    chk("tmo_regrant_addr", mem_addr, 32'h600);
    tick();
    respond(32'hABCD0001, 1'b1, 1'b0);
    tick();
    mem_ready = 1'b0; i_valid = 1'b0;
    smp();
    chk("tmo_idle", busy, 1'b0);
`else
    // Without the watchdog the arbiter waits indefinitely
    i_valid = 1'b1; i_addr = 32'h500;
    tick();
    i_addr = 32'h600;
    for (int n = 0; n < 20; n++) begin
      tick();
      smp();
      chk("wait_bus_fault", bus_fault, 1'b0);
      chk("wait_mem_valid", mem_valid, 1'b1);
    end
    chk("wait_addr", mem_addr, 32'h500);
    tick();
    respond(32'hABCD0001, 1'b1, 1'b0);
    tick();
    mem_ready = 1'b0; i_valid = 1'b0;
    smp();
    chk("wait_idle", busy, 1'b0);
`endif

    tick();
    tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single valid/ready memory port between two requesters:
  - instruction fetch (read-only);
  - the execute stage's load/store unit (read or write).
- Sits between the pipeline and the memory bus.
- Latches each granted request so the bus sees a stable transaction even if the requester drops or changes its request mid-flight.
- Alternates grants under contention so neither side starves.

Parameters:
- ADDR_W, 32, address width (word-aligned addresses are passed through; the arbiter does not align them).
- TIMEOUT_CYCLES, 255, cycles without mem_ready before abort. Used only when ARB_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_valid  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  fetch completion pulse
- i_rdata  out  32  fetch read data
- d_valid  in  1  load/store request
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  byte strobes; 0 = load
- d_ready  out  1  data completion pulse
- d_rdata  out  32  load read data
- mem_valid  out  1  bus request
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  32  bus write data
- mem_wstrb  out  4  bus strobes
- mem_ready  in  1  bus completion, one-cycle pulse
- mem_rdata  in  32  bus read data, valid with mem_ready
- busy  out  1  state != IDLE
- bus_fault  out  1  timeout abort pulse

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rstn.
- Reset values:
  - state = IDLE;
  - mem_valid, mem_addr, mem_wdata, mem_wstrb = 0;
  - last_grant = DATA, so fetch wins the first contention;
  - busy = 0, bus_fault = 0, timeout counter = 0.
- States:
  - IDLE
  - FETCH: bus owned by fetch.
  - DATA: bus owned by load/store.
- IDLE transitions, evaluated at the clock edge:
  - both valid: grant the side not equal to last_grant;
  - else grant whichever is valid;
  - else stay in IDLE.
- On grant:
  - latch the owner's addr into mem_addr;
  - for DATA, latch wdata/wstrb; for FETCH, mem_wstrb = 0 and mem_wdata = 0;
  - set mem_valid = 1 and last_grant = owner.
- Arbitration latency: one cycle, so mem_valid is first high on the cycle after the request is sampled.
- mem_valid, mem_addr, mem_wdata, mem_wstrb are registered. They are held constant while in FETCH/DATA until mem_ready, whatever the requester does.
- Completion, when mem_ready = 1 in FETCH/DATA:
  - the owner's ready = mem_ready AND owner valid, combinational in the same cycle;
  - if the owner has already dropped valid, the response is discarded and no ready pulse is issued;
  - the non-owner's ready is always 0.
- Back-to-back transfers, decided in the completion cycle:
  - if the other side is valid, go directly to its state and latch its request (mem_valid stays 1, zero bubble);
  - else if the same side is still valid, return to IDLE first (one-cycle bubble; this gives the other side a chance);
  - else go to IDLE.
- i_rdata = d_rdata = mem_rdata, combinational passthrough; meaningful only with the corresponding ready.
- mem_ready while in IDLE is ignored: no ready pulse, no state change.
- Reset mid-transaction: all state is cleared immediately. Any outstanding bus response after reset is ignored, because state is IDLE.
- busy = (state != IDLE).
- bus_fault is always 0 without the optional feature.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - a 16-bit counter clears on grant and increments each cycle in FETCH/DATA without mem_ready;
  - when the counter reaches TIMEOUT_CYCLES, the next edge forces IDLE, mem_valid = 0, and bus_fault = 1 for exactly one cycle;
  - no ready pulse is issued to the owner, and last_grant is unchanged;
  - mem_ready arriving in that same cycle takes precedence: normal completion, no fault.
- Undefined: no counter is instantiated, bus_fault is tied to 0, and the arbiter waits indefinitely.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding ARB_IDLE = 2'd0, ARB_FETCH = 2'd1, ARB_DATA = 2'd2;
  - grant owner constants OWN_FETCH = 1'b0, OWN_DATA = 1'b1;
  - TIMEOUT counter width 16.
- One natural sub-module, mem_arb_watchdog: counter plus compare, instantiated only under ARB_TIMEOUT_EN.
- Arbitration and the latch stay in the top module.

Test Plan:
- Single fetch: i_valid=1, i_addr=0x100, mem_ready two cycles after mem_valid with rdata=0xDEADBEEF -> mem_valid rises 1 cycle after i_valid, mem_addr=0x100, mem_wstrb=0, one i_ready pulse with i_rdata=0xDEADBEEF, d_ready stays 0.
- Contention after reset: i_valid and d_valid both high (d_addr=0x200, d_wstrb=4'b0011, d_wdata=0x1234) -> fetch served first; on its mem_ready the state goes directly to DATA with mem_valid still 1, mem_addr=0x200, mem_wstrb=0011; then d_ready.
- Starvation check: both held valid continuously for 10 transactions -> grants alternate FETCH, DATA, FETCH...; each side completes exactly 5.
- Requester drop: grant fetch at 0x300, then i_valid deasserted next cycle, mem_ready 3 cycles later -> mem_addr stays 0x300 until mem_ready, no i_ready, state returns to IDLE.
- Async reset mid-DATA: rstn low between edges -> mem_valid=0, busy=0 immediately; a later mem_ready produces no d_ready.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4, mem_ready never asserted -> after 4 waiting cycles, mem_valid falls, bus_fault is high for 1 cycle, and a new request is then granted normally.
